// File: rtl/tree_mac_issue_scheduler.sv
// Issue scheduler for the pipelined tree dot-product core: walks an I x K job row-major,
// one beat per cycle, throttled by credits held against the downstream result buffer.
module tree_mac_issue_scheduler #(
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int CREDITS         = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [ADDRESS_WIDTH_I-1:0] num_i,
  input  logic [ADDRESS_WIDTH_K-1:0] num_k,
  output logic                       busy,
  output logic                       done,
  output logic                       issue_val,
  output logic [ADDRESS_WIDTH_I-1:0] issue_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0] issue_addr_k,
  input  logic                       core_val_out,
  input  logic                       res_pop,
  output logic [CNT_WIDTH-1:0]       stall_cycles
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH_I-1:0] numI_q, numI_d, idxI_q, idxI_d, issueAddrI_q, issueAddrI_d;
  logic [ADDRESS_WIDTH_K-1:0] numK_q, numK_d, idxK_q, idxK_d, issueAddrK_q, issueAddrK_d;
  logic                       issueVal_q, issueVal_d;
  logic [CW-1:0]              credits_q, credits_d, outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]       stall_q, stall_d;
  logic [CW-1:0]              coreInFlight_q;
  logic                       issue;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      numI_q        <= '0;
      numK_q        <= '0;
      idxI_q        <= '0;
      idxK_q        <= '0;
      issueVal_q    <= 1'b0;
      issueAddrI_q  <= '0;
      issueAddrK_q  <= '0;
      credits_q     <= CREDITS_FULL;
      outstanding_q <= '0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      numI_q        <= numI_d;
      numK_q        <= numK_d;
      idxI_q        <= idxI_d;
      idxK_q        <= idxK_d;
      issueVal_q    <= issueVal_d;
      issueAddrI_q  <= issueAddrI_d;
      issueAddrK_q  <= issueAddrK_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      stall_q       <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    numI_d       = numI_q;
    numK_d       = numK_q;
    idxI_d       = idxI_q;
    idxK_d       = idxK_q;
    issueVal_d   = 1'b0;
    issueAddrI_d = issueAddrI_q;
    issueAddrK_d = issueAddrK_q;
    stall_d      = stall_q;
    issue        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          numI_d  = num_i;
          numK_d  = num_k;
          idxI_d  = '0;
          idxK_d  = '0;
          stall_d = '0;
          state_d = (num_i == '0 || num_k == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (credits_q != '0) begin
          issue        = 1'b1;
          issueVal_d   = 1'b1;
          issueAddrI_d = idxI_q;
          issueAddrK_d = idxK_q;
          // Terminal compares against num-1 so full-scale sizes never need a wrapped index.
          if (idxK_q == numK_q - ADDRESS_WIDTH_K'(1)) begin
            idxK_d = '0;
            if (idxI_q == numI_q - ADDRESS_WIDTH_I'(1)) begin
              state_d = DRAIN;
            end else begin
              idxI_d = idxI_q + ADDRESS_WIDTH_I'(1);
            end
          end else begin
            idxK_d = idxK_q + ADDRESS_WIDTH_K'(1);
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A pop arriving with the pool already full is a protocol error and is dropped.
  always_comb begin
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    if (issue && !res_pop) begin
      credits_d     = credits_q - CW'(1);
      outstanding_d = outstanding_q + CW'(1);
    end else if (!issue && res_pop) begin
      if (credits_q != CREDITS_FULL) begin
        credits_d = credits_q + CW'(1);
      end
      if (outstanding_q != '0) begin
        outstanding_d = outstanding_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coreInFlight_q <= '0;
    end else if (issueVal_q && !core_val_out) begin
      coreInFlight_q <= coreInFlight_q + CW'(1);
    end else if (!issueVal_q && core_val_out && coreInFlight_q != '0) begin
      coreInFlight_q <= coreInFlight_q - CW'(1);
    end
  end

  // Debug only: the core must never return more results than beats it was handed.
  always @(posedge clk) begin
    if (reset_n && core_val_out) begin
      assert (coreInFlight_q != '0);
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign issue_val    = issueVal_q;
  assign issue_addr_i = issueAddrI_q;
  assign issue_addr_k = issueAddrK_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_tree_mac_issue_scheduler.sv
// Scoreboard bench for tree_mac_issue_scheduler: expected beats are queued at job start and
// popped by a monitor; a small core/result-buffer model returns credits.
module tb_tree_mac_issue_scheduler;

  localparam int AWI  = 8;
  localparam int AWK  = 8;
  localparam int CRED = 4;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [AWI-1:0]  num_i;
  logic [AWK-1:0]  num_k;
  logic            busy;
  logic            done;
  logic            issue_val;
  logic [AWI-1:0]  issue_addr_i;
  logic [AWK-1:0]  issue_addr_k;
  logic            core_val_out;
  logic            res_pop;
  logic [CNTW-1:0] stall_cycles;

  int          compared = 0;
  int          failed = 0;
  logic [15:0] expQ[$];
  int          beatCount = 0;
  int          firstBeat = 0;
  int          lastBeat = 0;
  int          cycleCount = 0;
  int          doneCount = 0;
  int          popsIssued = 0;
  int          stored = 0;
  logic        lastIssue = 1'b0;
  bit          popEn = 1'b0;

  tree_mac_issue_scheduler #(
    .ADDRESS_WIDTH_I(AWI),
    .ADDRESS_WIDTH_K(AWK),
    .CREDITS(CRED),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .num_i(num_i),
    .num_k(num_k),
    .busy(busy),
    .done(done),
    .issue_val(issue_val),
    .issue_addr_i(issue_addr_i),
    .issue_addr_k(issue_addr_k),
    .core_val_out(core_val_out),
    .res_pop(res_pop),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Core with one cycle of latency feeding a result buffer that pops one entry per cycle when enabled.
  initial begin
    core_val_out = 1'b0;
    res_pop      = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        core_val_out = 1'b0;
        res_pop      = 1'b0;
        lastIssue    = 1'b0;
        stored       = 0;
      end else begin
        stored = stored + int'(core_val_out) - int'(res_pop);
        res_pop = popEn && (stored > 0);
        if (res_pop) popsIssued++;
        core_val_out = lastIssue;
        lastIssue    = issue_val;
      end
    end
  end

  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      cycleCount++;
      if (reset_n && issue_val) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 1, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("beatI", int'(issue_addr_i), int'(exp[15:8]));
          checkOutput("beatK", int'(issue_addr_k), int'(exp[7:0]));
        end
        if (beatCount == 0) firstBeat = cycleCount;
        lastBeat = cycleCount;
        beatCount++;
      end
      if (reset_n && done) doneCount++;
    end
  end

  task automatic applyStimulus(input int ni, input int nk);
    for (int i = 0; i < ni; i++) begin
      for (int k = 0; k < nk; k++) begin
        expQ.push_back({8'(i), 8'(k)});
      end
    end
    beatCount = 0;
    @(negedge clk);
    num_i = 8'(ni);
    num_k = 8'(nk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int popsBefore;
    int doneBefore;
    reset_n = 1'b0;
    start   = 1'b0;
    num_i   = '0;
    num_k   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstIssueVal", int'(issue_val), 0);
    checkOutput("rstAddrI", int'(issue_addr_i), 0);
    checkOutput("rstAddrK", int'(issue_addr_k), 0);
    checkOutput("rstStall", int'(stall_cycles), 0);
    reset_n = 1'b1;

    // 2x3 job with prompt pops: six back-to-back beats, credits recycle with same-cycle issue/pop.
    popEn = 1'b1;
    popsBefore = popsIssued;
    applyStimulus(2, 3);
    waitDone("t1Done", 60);
    checkOutput("t1Beats", beatCount, 6);
    checkOutput("t1Consecutive", lastBeat - firstBeat, 5);
    checkOutput("t1Stall", int'(stall_cycles), 0);
    checkOutput("t1Pops", popsIssued - popsBefore, 6);
    checkOutput("t1QueueEmpty", expQ.size(), 0);
    @(negedge clk);
    checkOutput("t1DoneOneCycle", int'(done), 0);
    checkOutput("t1BusyIdle", int'(busy), 0);

    // 1x8 job with pops held off: four beats then stall until pops resume.
    popEn = 1'b0;
    applyStimulus(1, 8);
    repeat (18) @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("t2StallMid", int'(stall_cycles), 15);
    checkOutput("t2BeatsBeforePop", beatCount, 4);
    popEn = 1'b1;
    waitDone("t2Done", 100);
    checkOutput("t2StallFinal", int'(stall_cycles), 16);
    checkOutput("t2Beats", beatCount, 8);
    checkOutput("t2QueueEmpty", expQ.size(), 0);
    @(negedge clk);

    // Empty job: one DONE cycle, no beats, stall counter cleared on start.
    applyStimulus(0, 5);
    checkOutput("t3BusyDone", int'(busy), 1);
    checkOutput("t3DonePulse", int'(done), 1);
    checkOutput("t3StallCleared", int'(stall_cycles), 0);
    @(negedge clk);
    checkOutput("t3BusyLow", int'(busy), 0);
    checkOutput("t3DoneLow", int'(done), 0);
    repeat (4) @(negedge clk);
    checkOutput("t3NoBeats", beatCount, 0);

    // Start re-pulsed mid-run with a different size must be ignored.
    doneBefore = doneCount;
    applyStimulus(2, 3);
    @(negedge clk);
    num_i = 8'd3;
    num_k = 8'd2;
    start = 1'b1;
    checkOutput("t5BusyAtRestart", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    waitDone("t5Done", 60);
    @(negedge clk);
    checkOutput("t5Beats", beatCount, 6);
    checkOutput("t5DoneCount", doneCount - doneBefore, 1);
    checkOutput("t5QueueEmpty", expQ.size(), 0);

    // Reset mid-run aborts to reset values with no done pulse; a fresh job then runs.
    doneBefore = doneCount;
    applyStimulus(1, 8);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t6Busy", int'(busy), 0);
    checkOutput("t6Done", int'(done), 0);
    checkOutput("t6IssueVal", int'(issue_val), 0);
    checkOutput("t6AddrI", int'(issue_addr_i), 0);
    checkOutput("t6AddrK", int'(issue_addr_k), 0);
    checkOutput("t6Stall", int'(stall_cycles), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 2);
    waitDone("t6NewDone", 40);
    @(negedge clk);
    checkOutput("t6DoneCount", doneCount - doneBefore, 1);
    checkOutput("t6Beats", beatCount, 2);
    checkOutput("t6NewStall", int'(stall_cycles), 0);
    checkOutput("t6QueueEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
